fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register; the consumer of the branch unit's PC_source decision.
- Holds the program counter and drives the instruction-memory address.
- Each cycle it selects the sequential PC or the decode-stage branch target, and flushes the wrong-path instruction on a taken branch.
- Supports decode stall and a sticky halt.

---
 rtl/processor_pkg.sv | 25 ++
 rtl/fetch_stage_pc_next_logic.sv | 28 ++
 rtl/fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the processor pipeline: widths, NOP,
// fetch FSM encoding, next-PC selects and branch-condition codes.
package processor_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 16;

   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [1:0] PC_SEL_HOLD = 2'd0;
   localparam logic [1:0] PC_SEL_INC  = 2'd1;
   localparam logic [1:0] PC_SEL_TGT  = 2'd2;

   localparam logic [2:0] BR_NEVER  = 3'd0;
   localparam logic [2:0] BR_EQ     = 3'd1;
   localparam logic [2:0] BR_NE     = 3'd2;
   localparam logic [2:0] BR_LT     = 3'd3;
   localparam logic [2:0] BR_GE     = 3'd4;
   localparam logic [2:0] BR_ALWAYS = 3'd5;

endpackage

// File: rtl/fetch_stage_pc_next_logic.sv
// Combinational next-PC mux: hold, sequential +1 (wraps), or target.
// Also exposes PC+1 for the IF/ID register.
module pc_next_logic
   import processor_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] target_i,
   input  logic [1:0]      sel_i,
   output logic [PC_W-1:0] pc_next_o,
   output logic [PC_W-1:0] pc_inc_o
);

   localparam logic [PC_W-1:0] ONE = PC_W'(1);

   // Select the next PC; the +1 result truncates, giving modulo wrap
   always_comb begin
      pc_inc_o  = pc_i + ONE;
      pc_next_o = pc_i;
      unique case (sel_i)
         PC_SEL_INC: pc_next_o = pc_inc_o;
         PC_SEL_TGT: pc_next_o = target_i;
         default:    pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, boot/run/halt FSM and IF/ID register.
// Optional BRANCH_DELAY_SLOT_EN keeps the post-branch fetch as a delay slot.
module fetch_stage
   import processor_pkg::*;
#(
   parameter int              PC_W         = PC_W_DEF,
   parameter int              INSTR_W      = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               PC_source,
   input  logic [PC_W-1:0]    branch_target_d,
   input  logic               stall_d,
   input  logic               halt_d,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction_d,
   output logic [PC_W-1:0]    pc_plus1_d,
   output logic               valid_d,
   output logic               halted
);

   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

   logic [1:0]         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]    npc_q, npc_d;
   logic               vld_q, vld_d;
   logic [1:0]         pc_sel;
   logic [PC_W-1:0]    pc_inc;

   pc_next_logic #(
      .PC_W(PC_W)
   ) u_pc_next (
      .pc_i     (pc_q),
      .target_i (branch_target_d),
      .sel_i    (pc_sel),
      .pc_next_o(pc_d),
      .pc_inc_o (pc_inc)
   );

   // FSM and IF/ID next-state: halt > stall > branch > sequential
   always_comb begin
      state_d = state_q;
      pc_sel  = PC_SEL_HOLD;
      ir_d    = ir_q;
      npc_d   = npc_q;
      vld_d   = vld_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
            vld_d   = 1'b0;
         end
         S_RUN: begin
            if (halt_d) begin
               state_d = S_HALT;
               ir_d    = NOP;
               vld_d   = 1'b0;
            end else if (stall_d) begin
               pc_sel = PC_SEL_HOLD;
            end else if (PC_source) begin
               pc_sel = PC_SEL_TGT;
`ifdef BRANCH_DELAY_SLOT_EN
               ir_d   = imem_rdata;
               npc_d  = pc_inc;
               vld_d  = 1'b1;
`else
               ir_d   = NOP;
               vld_d  = 1'b0;
`endif
            end else begin
               pc_sel = PC_SEL_INC;
               ir_d   = imem_rdata;
               npc_d  = pc_inc;
               vld_d  = 1'b1;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_BOOT;
            vld_d   = 1'b0;
         end
      endcase
   end

   // PC, FSM and IF/ID registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         ir_q    <= NOP;
         npc_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         npc_q   <= npc_d;
         vld_q   <= vld_d;
      end
   end

   assign imem_addr     = pc_q;
   assign instruction_d = ir_q;
   assign pc_plus1_d    = npc_q;
   assign valid_d       = vld_q;
   assign halted        = (state_q == S_HALT);

endmodule
